// File: rtl/sp_pkg.sv
// Shared definitions for the serial-to-parallel converter and its output buffer.
package sp_pkg;

    localparam int SP_DATA_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sp_state_e;

    // Depth of the output buffer in words; the level counter needs one more code.
    localparam int SP_FIFO_DEPTH = 2;

endpackage : sp_pkg

// File: rtl/sp_out_fifo.sv
// Two-entry output buffer; the head word is held in its own register so dout is glitch-free.
module sp_out_fifo
    import sp_pkg::*;
#(
    parameter int WIDTH = SP_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push into a full buffer only succeeds when the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = pop && (level_r != 2'd0);
        push_ok_s = push && ((level_r != 2'd2) || pop_ok_s);
    end

    // Buffer storage and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            level_r <= 2'd0;
        end else begin
            case (level_r)
                2'd0: begin
                    if (push_ok_s) begin
                        head_r  <= push_data;
                        level_r <= 2'd1;
                    end else begin
                        level_r <= 2'd0;
                    end
                end
                2'd1: begin
                    case ({push_ok_s, pop_ok_s})
                        2'b10: begin
                            tail_r  <= push_data;
                            level_r <= 2'd2;
                        end
                        2'b01: begin
                            level_r <= 2'd0;
                        end
                        2'b11: begin
                            head_r  <= push_data;
                            level_r <= 2'd1;
                        end
                        default: begin
                            level_r <= 2'd1;
                        end
                    endcase
                end
                2'd2: begin
                    if (pop_ok_s) begin
                        head_r <= tail_r;
                        if (push_ok_s) begin
                            tail_r  <= push_data;
                            level_r <= 2'd2;
                        end else begin
                            level_r <= 2'd1;
                        end
                    end else begin
                        level_r <= 2'd2;
                    end
                end
                default: begin
                    level_r <= 2'd0;
                end
            endcase
        end
    end

    assign dout  = head_r;
    assign full  = (level_r == 2'd2);
    assign empty = (level_r == 2'd0);

endmodule : sp_out_fifo

// File: rtl/serial2parallel.sv
// Serial bit stream to parallel word converter with sof alignment and a two-word output buffer.
module serial2parallel
    import sp_pkg::*;
#(
    parameter int DATA_W    = SP_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun,
    output logic              sync_err
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    sp_state_e         state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              sync_err_r;
    logic              overrun_r;

    logic [DATA_W-1:0] base_s;
    logic [DATA_W-1:0] word_s;
    logic              start_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;

    // Next shift-register value; an sof restarts assembly from a clean word.
    always_comb begin
        start_s = din_valid && sof;
        if (start_s) begin
            base_s = '0;
        end else begin
            base_s = shift_r;
        end
        if (MSB_FIRST) begin
            word_s = {base_s[DATA_W-2:0], din};
        end else begin
            word_s = {din, base_s[DATA_W-1:1]};
        end
    end

    // A word completes only on a non-sof bit, since an sof always restarts at count one.
    always_comb begin
        if (din_valid && !sof && (state_r == SHIFT) && (cnt_r == CNT_LAST)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s = dout_ready && !empty_s;
    end

    // Alignment FSM, bit counter, shift register and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            shift_r    <= '0;
            sync_err_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            overrun_r  <= push_s && full_s && !pop_s;
            sync_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        shift_r <= word_s;
                        cnt_r   <= CNT_ONE;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (din_valid) begin
                        shift_r <= word_s;
                        if (sof) begin
                            cnt_r      <= CNT_ONE;
                            sync_err_r <= (cnt_r != CNT_ZERO);
                        end else if (cnt_r == CNT_LAST) begin
                            cnt_r <= CNT_ZERO;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    sp_out_fifo #(
        .WIDTH(DATA_W)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .push_data(word_s),
        .pop      (pop_s),
        .dout     (dout),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign dout_valid = !empty_s;
    assign overrun    = overrun_r;
    assign sync_err   = sync_err_r;

endmodule : serial2parallel
